forwarding_hazard_unit: RTL



---
 rtl/hazard_pkg.sv | 25 ++
 rtl/forwarding_hazard_unit_if.sv | 50 +++++
 rtl/fwd_compare.sv | 46 ++++
 rtl/forwarding_hazard_unit.sv | 120 ++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the forwarding / hazard unit and the datapath
// operand muxes that consume its forward selects.
//   fwd_sel_t      : 2-bit operand forward select
//   FWD_*          : select encodings (11 is never produced)
//   stall_state_t  : load-use stall FSM states
//   REMAIN_W       : width of the remaining-bubble counter (covers 1..15)
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REGFILE = 2'b00;
    localparam fwd_sel_t FWD_EXMEM   = 2'b01;
    localparam fwd_sel_t FWD_MEMWB   = 2'b10;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } stall_state_t;

    localparam int REMAIN_W = 4;

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// -----------------------------------------------------------------------------
// forwarding_hazard_unit_if
// Pipeline-side bundle for the forwarding / hazard unit.
//   master : pipeline control (drives register addresses, write enables,
//            load flag, back-pressure, branch flush; receives selects/stalls)
//   slave  : forwarding_hazard_unit
// Parameters: REG_ADDR_W register address width, CNT_W stall counter width.
// -----------------------------------------------------------------------------
interface forwarding_hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    import hazard_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic [REG_ADDR_W-1:0] mem_rd_addr;
    logic                  ex_reg_write;
    logic                  mem_reg_write;
    logic                  ex_mem_read;
    logic                  mem_busy;
    logic                  flush_req;

    fwd_sel_t              fwd_sel_rs1;
    fwd_sel_t              fwd_sel_rs2;
    logic                  pc_stall;
    logic                  if_id_stall;
    logic                  id_ex_flush;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        output ex_rd_addr, mem_rd_addr, ex_reg_write, mem_reg_write,
        output ex_mem_read, mem_busy, flush_req,
        input  fwd_sel_rs1, fwd_sel_rs2, pc_stall, if_id_stall,
        input  id_ex_flush, stall_count
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        input  ex_rd_addr, mem_rd_addr, ex_reg_write, mem_reg_write,
        input  ex_mem_read, mem_busy, flush_req,
        output fwd_sel_rs1, fwd_sel_rs2, pc_stall, if_id_stall,
        output id_ex_flush, stall_count
    );

endinterface

// File: rtl/fwd_compare.sv
// -----------------------------------------------------------------------------
// fwd_compare
// Combinational compare of one ID source register against the EX and MEM
// destinations.
//   src_addr/src_used          : ID source address and whether it is read
//   ex_rd_addr/ex_reg_write    : destination of the instruction in EX
//   mem_rd_addr/mem_reg_write  : destination of the instruction in MEM
//   next_sel                   : select to register for when this op is in EX
//   ex_match                   : source depends on the EX instruction
// -----------------------------------------------------------------------------
module fwd_compare
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int ZERO_REG_EN = 1
) (
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic                  src_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_addr,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd_addr,
    input  logic                  mem_reg_write,
    output fwd_sel_t              next_sel,
    output logic                  ex_match
);

    logic src_valid;
    logic mem_match;

    // x0 is hardwired when enabled, so a write to it never produces a result.
    assign src_valid = src_used && ((ZERO_REG_EN == 0) || (src_addr != '0));
    assign ex_match  = src_valid && ex_reg_write  && (ex_rd_addr  == src_addr);
    assign mem_match = src_valid && mem_reg_write && (mem_rd_addr == src_addr);

    // The EX instruction is the younger producer, so it wins over MEM.
    // It sits in MEM when the consumer reaches EX, hence EX/MEM forwarding.
    always_comb begin
        next_sel = FWD_REGFILE;
        if (ex_match) begin
            next_sel = FWD_EXMEM;
        end else if (mem_match) begin
            next_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/forwarding_hazard_unit.sv
// -----------------------------------------------------------------------------
// forwarding_hazard_unit
// Operand forwarding selects and load-use stall control for the pipeline.
//   clk    : pipeline clock
//   reset  : asynchronous, active-high
//   bus    : forwarding_hazard_unit_if.slave (addresses, write enables, load
//            flag, mem_busy, flush_req in; fwd selects, pc_stall,
//            if_id_stall, id_ex_flush, stall_count out)
// Forward selects are registered so they line up with the instruction as it
// enters EX. Stall outputs are combinational in the detection cycle.
// -----------------------------------------------------------------------------
module forwarding_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W      = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int ZERO_REG_EN     = 1,
    parameter int CNT_W           = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    forwarding_hazard_unit_if.slave bus
);

    // Bubbles still owed after the detection cycle.
    localparam logic [REMAIN_W-1:0] STALL_EXTRA = REMAIN_W'(LOAD_USE_STALLS - 1);

    logic [REG_ADDR_W-1:0] src_addr [2];
    logic                  src_used [2];
    fwd_sel_t              next_sel [2];
    logic                  ex_match [2];

    stall_state_t          state_reg;
    logic [REMAIN_W-1:0]   remain_reg;
    fwd_sel_t              fwd_sel_reg [2];
    logic [CNT_W-1:0]      stall_count_reg;

    logic                  hazard;
    logic                  active;
    logic                  flush_cycle;
    logic                  stall_cycle;

    assign src_addr[0] = bus.id_rs1_addr;
    assign src_addr[1] = bus.id_rs2_addr;
    assign src_used[0] = bus.id_rs1_used;
    assign src_used[1] = bus.id_rs2_used;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cmp
            fwd_compare #(
                .REG_ADDR_W  (REG_ADDR_W),
                .ZERO_REG_EN (ZERO_REG_EN)
            ) u_cmp (
                .src_addr      (src_addr[gi]),
                .src_used      (src_used[gi]),
                .ex_rd_addr    (bus.ex_rd_addr),
                .ex_reg_write  (bus.ex_reg_write),
                .mem_rd_addr   (bus.mem_rd_addr),
                .mem_reg_write (bus.mem_reg_write),
                .next_sel      (next_sel[gi]),
                .ex_match      (ex_match[gi])
            );
        end
    endgenerate

    // A load in EX cannot forward its data until it leaves MEM.
    assign hazard      = bus.ex_mem_read && (ex_match[0] || ex_match[1]);
    // mem_busy already freezes the pipeline externally, so nothing is asserted.
    assign active      = !reset && !bus.mem_busy;
    assign flush_cycle = active && bus.flush_req;
    assign stall_cycle = active && !bus.flush_req &&
                         ((state_reg == STALL) || hazard);

    assign bus.pc_stall    = stall_cycle;
    assign bus.if_id_stall = stall_cycle;
    assign bus.id_ex_flush = stall_cycle || flush_cycle;
    assign bus.fwd_sel_rs1 = fwd_sel_reg[0];
    assign bus.fwd_sel_rs2 = fwd_sel_reg[1];
    assign bus.stall_count = stall_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= RUN;
            remain_reg      <= '0;
            fwd_sel_reg[0]  <= FWD_REGFILE;
            fwd_sel_reg[1]  <= FWD_REGFILE;
            stall_count_reg <= '0;
        end else if (!bus.mem_busy) begin
            if (bus.flush_req) begin
                state_reg      <= RUN;
                remain_reg     <= '0;
                fwd_sel_reg[0] <= FWD_REGFILE;
                fwd_sel_reg[1] <= FWD_REGFILE;
            end else if (stall_cycle) begin
                // The bubble entering EX consumes no operands.
                fwd_sel_reg[0] <= FWD_REGFILE;
                fwd_sel_reg[1] <= FWD_REGFILE;
                if (stall_count_reg != {CNT_W{1'b1}}) begin
                    stall_count_reg <= stall_count_reg + 1'b1;
                end
                if (state_reg == RUN) begin
                    if (LOAD_USE_STALLS > 1) begin
                        state_reg  <= STALL;
                        remain_reg <= STALL_EXTRA;
                    end
                end else begin
                    remain_reg <= remain_reg - 1'b1;
                    if (remain_reg == REMAIN_W'(1)) begin
                        state_reg <= RUN;
                    end
                end
            end else begin
                fwd_sel_reg[0] <= next_sel[0];
                fwd_sel_reg[1] <= next_sel[1];
            end
        end
    end

endmodule
